// File: rtl/pmc_pkg.sv
// Shared types and constants for the power management controller.
package pmc_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'b00,
        ST_QUIESCE = 2'b01,
        ST_DOWN    = 2'b10,
        ST_WAKE    = 2'b11
    } pmc_state_t;

    localparam int DOM_RT      = 0;
    localparam int DOM_GP      = 1;
    localparam int DOM_PERIPH  = 2;
    localparam int NUM_DOMAINS = 3;

    // One counter serves all three timed states, so it must hold the largest limit.
    function automatic int unsigned pmc_cnt_width(input int unsigned a, input int unsigned b,
                                                  input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pmc_domain_fsm.sv
// One power domain: quiesce handshake, DOWN residency with pending wake, stable-clock wake timer.
//   state   | meaning
//   ACTIVE  | domain running, ready
//   QUIESCE | waiting for quiesce_ack, timeout armed
//   DOWN    | power_down asserted, residency counting
//   WAKE    | power_down released, counting stable clocks
module pmc_domain_fsm
    import pmc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned WAKE_CYCLES     = 32,
    parameter int unsigned QUIESCE_TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clocks_stable_i,
    input  logic       sleep_req_i,
    input  logic       wake_event_i,
    input  logic       quiesce_ack_i,
    input  logic       sleep_allow_i,
    input  logic       force_wake_i,
    output pmc_state_t state_o,
    output logic       quiesce_req_o,
    output logic       power_down_o,
    output logic       leave_down_o,
    output logic       timeout_o
);

    localparam int unsigned CNT_W = pmc_cnt_width(SETTLE_CYCLES, WAKE_CYCLES, QUIESCE_TIMEOUT);

    pmc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      cnt_elapsed;
    logic             wake_cond;
    logic             resid_done;

    // cnt_elapsed counts the current cycle too, so "N cycles in state" compares against N.
    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign cnt_elapsed = 32'(cnt_q) + 32'd1;
    assign wake_cond   = wake_event_i || !sleep_req_i;
    assign resid_done  = cnt_elapsed >= SETTLE_CYCLES;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        timeout_o = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (sleep_req_i && clocks_stable_i && !wake_event_i && sleep_allow_i) begin
                    state_d = ST_QUIESCE;
                    cnt_d   = '0;
                end
            end
            ST_QUIESCE: begin
                if (wake_cond) begin
                    state_d = ST_ACTIVE;
                end else if (quiesce_ack_i) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (cnt_elapsed >= QUIESCE_TIMEOUT) begin
                    state_d   = ST_ACTIVE;
                    timeout_o = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DOWN: begin
                if (force_wake_i || (resid_done && (pend_q || wake_cond))) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (!resid_done) begin
                    cnt_d = cnt_inc;
                    if (wake_cond) pend_d = 1'b1;
                end
            end
            ST_WAKE: begin
                if (clocks_stable_i) begin
                    if (cnt_elapsed >= WAKE_CYCLES) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign state_o       = state_q;
    assign quiesce_req_o = (state_q != ST_ACTIVE);
    assign power_down_o  = (state_q == ST_DOWN);
    assign leave_down_o  = (state_q == ST_DOWN) && (state_d != ST_DOWN);

endmodule

// File: rtl/power_management_controller.sv
// Sleep/wake sequencer for RT, GP and peripheral domains with peripheral interlock and
// sticky quiesce-timeout flags.
module power_management_controller
    import pmc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned WAKE_CYCLES     = 32,
    parameter int unsigned QUIESCE_TIMEOUT = 1024
) (
    input  logic       clk_debug_10mhz,
    input  logic       rst_n_debug,
    input  logic       clocks_stable,
    input  logic [2:0] sleep_req,
    input  logic [2:0] wake_event,
    output logic [2:0] quiesce_req,
    input  logic [2:0] quiesce_ack,
    output logic       power_down_rt,
    output logic       power_down_gp,
    output logic       power_down_periph,
    output logic [5:0] domain_state,
    output logic [2:0] domain_ready,
    output logic [2:0] timeout_err,
    input  logic       err_clear
);

    pmc_state_t rt_state, gp_state, periph_state;
    logic       rt_leave, gp_leave, periph_leave_unused;
    logic       rt_tmo, gp_tmo, periph_tmo;
    logic       periph_allow, periph_force;
    logic [2:0] err_q, err_d;

    // Peripheral may only sleep behind both cores and is pulled up on the edge either core wakes.
    assign periph_allow = (rt_state == ST_DOWN) && (gp_state == ST_DOWN);
    assign periph_force = rt_leave || gp_leave;

    pmc_domain_fsm #(
        .SETTLE_CYCLES(SETTLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .QUIESCE_TIMEOUT(QUIESCE_TIMEOUT)
    ) u_rt (
        .clk_i(clk_debug_10mhz), .rst_n_i(rst_n_debug), .clocks_stable_i(clocks_stable),
        .sleep_req_i(sleep_req[DOM_RT]), .wake_event_i(wake_event[DOM_RT]),
        .quiesce_ack_i(quiesce_ack[DOM_RT]), .sleep_allow_i(1'b1), .force_wake_i(1'b0),
        .state_o(rt_state), .quiesce_req_o(quiesce_req[DOM_RT]), .power_down_o(power_down_rt),
        .leave_down_o(rt_leave), .timeout_o(rt_tmo)
    );

    pmc_domain_fsm #(
        .SETTLE_CYCLES(SETTLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .QUIESCE_TIMEOUT(QUIESCE_TIMEOUT)
    ) u_gp (
        .clk_i(clk_debug_10mhz), .rst_n_i(rst_n_debug), .clocks_stable_i(clocks_stable),
        .sleep_req_i(sleep_req[DOM_GP]), .wake_event_i(wake_event[DOM_GP]),
        .quiesce_ack_i(quiesce_ack[DOM_GP]), .sleep_allow_i(1'b1), .force_wake_i(1'b0),
        .state_o(gp_state), .quiesce_req_o(quiesce_req[DOM_GP]), .power_down_o(power_down_gp),
        .leave_down_o(gp_leave), .timeout_o(gp_tmo)
    );

    pmc_domain_fsm #(
        .SETTLE_CYCLES(SETTLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .QUIESCE_TIMEOUT(QUIESCE_TIMEOUT)
    ) u_periph (
        .clk_i(clk_debug_10mhz), .rst_n_i(rst_n_debug), .clocks_stable_i(clocks_stable),
        .sleep_req_i(sleep_req[DOM_PERIPH]), .wake_event_i(wake_event[DOM_PERIPH]),
        .quiesce_ack_i(quiesce_ack[DOM_PERIPH]), .sleep_allow_i(periph_allow),
        .force_wake_i(periph_force), .state_o(periph_state),
        .quiesce_req_o(quiesce_req[DOM_PERIPH]), .power_down_o(power_down_periph),
        .leave_down_o(periph_leave_unused), .timeout_o(periph_tmo)
    );

    // A timeout landing with err_clear keeps its bit set.
    assign err_d = (err_q & ~{3{err_clear}}) | {periph_tmo, gp_tmo, rt_tmo};

    always_ff @(posedge clk_debug_10mhz or negedge rst_n_debug) begin
        if (!rst_n_debug) err_q <= '0;
        else              err_q <= err_d;
    end

    assign timeout_err  = err_q;
    assign domain_state = {periph_state, gp_state, rt_state};
    assign domain_ready = {periph_state == ST_ACTIVE, gp_state == ST_ACTIVE, rt_state == ST_ACTIVE};

endmodule
